poly_store_control_bram: RTL
============================

Name: poly_store_control_bram

Overview:
- Write-side counterpart of the polynomial load controller.
- Accepts a stream of 256 result coefficients (13 bits each) from the multiplier, packs them LSB-first into 64-bit words and writes 52 consecutive BRAM words at addresses 0..51.
- Asserts done after the last word is written.
- Sits between the multiplier accumulator readout and the result BRAM port.

Parameters:
- COEF_W, 13, coefficient width in bits
- N_COEF, 256, coefficients per polynomial
- WORD_W, 64, BRAM data width
- N_WORDS, 52, words per polynomial; N_COEF*COEF_W must equal N_WORDS*WORD_W
- ADDR_W, 8, BRAM address width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin storing one polynomial; sampled in IDLE or DONE only
- coef_in  in  COEF_W  coefficient data
- coef_valid  in  1  coef_in is valid
- coef_ready  out  1  block accepts coef_in this cycle
- we  out  1  BRAM write enable
- waddr  out  ADDR_W  BRAM write address
- wdata  out  WORD_W  BRAM write data
- busy  out  1  high in PACK
- done  out  1  polynomial fully written; level

Behaviour:
- Reset (rst=1 at a clk edge) applies from any state, including mid-polynomial; no further writes are issued. After reset:
  - coef_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0
  - state IDLE
  - coef_count=0, word_count=0, fill=0, pack buffer=0
- States: IDLE, PACK, DONE.
  - IDLE -> PACK on start. This clears coef_count, word_count, fill and buffer, and sets done=0.
  - DONE -> PACK on start, with the same clearing. DONE otherwise holds done=1.
  - start during PACK is ignored.
- coef_ready = (state==PACK) && (coef_count < N_COEF). It is combinational from state.
- Accept: a coefficient is accepted on a cycle where coef_valid && coef_ready.
  - The value is OR-ed into the pack buffer at bit offset fill. The buffer is WORD_W+COEF_W-1 = 76 bits.
  - coef_count increments.
- Word emit: on an accept where fill+COEF_W >= WORD_W:
  - On the next cycle: we=1, wdata = low WORD_W bits of the updated buffer, waddr = word_count.
  - The buffer shifts right by WORD_W, fill becomes fill+COEF_W-WORD_W, and word_count increments.
  - Otherwise fill becomes fill+COEF_W and we=0 on the next cycle.
- Write latency: exactly 1 cycle from the accepting edge to the we pulse. At most one write per accept, so coef_ready never deasserts for backpressure.
- we is a single-cycle pulse per word. waddr and wdata are registered and hold their last value when we=0.
- Gaps: coef_valid gaps are allowed anywhere; state and fill are held.
- Completion: the write of word N_WORDS-1 (address 51) coincides with the cycle the FSM enters DONE.
  - done=1 and busy=0 on that same cycle.
  - fill must be 0 at that point, since 3328 bits is a whole number of words.
- Coefficients presented after the 256th are not accepted (coef_ready=0).
- The address counter never wraps past N_WORDS-1.

Decomposition:
- Shared package holds:
  - POLY_N=256, SABER_COEF_W=13, BRAM_WORD_W=64, POLY_WORDS=52
  - the state encoding (IDLE=2'd0, PACK=2'd1, DONE=2'd2)
- One natural sub-module, poly_coef_packer: the buffer, fill counter and emit flag. It is shared later with the unpacking direction's tests.
- The FSM, counters and BRAM port registers stay in the top.

Test Plan:
- Ramp: rst, start, coef_i=i for i=0..255 with coef_valid held high.
  - First we one cycle after the 5th accept.
  - waddr=0, wdata=0x0040_0180_0800_2000.
  - 52 we pulses at addresses 0..51; done=1 at the word-51 write; busy=0 after.
- All-ones: coef_i=0x1FFF for all i.
  - Every wdata=0xFFFF_FFFF_FFFF_FFFF; exactly 52 writes; fill=0 at done.
- Random valid gaps (~50% duty), random coefficients.
  - Written words match the golden pack model bit-exactly.
  - Write timing is one cycle after each emitting accept.
  - coef_ready stays 1 until 256 accepts.
- Reset mid-stream: rst after 100 accepts.
  - we=0, done=0, busy=0, waddr=0 next cycle.
  - New start plus a 256-coefficient ramp yields the same 52 words as the first test.
- Start while busy: pulse start at accept 30; no restart, counters unaffected, output identical to the first test.
- Restart from DONE: second start after done, with coef_i=255-i.
  - done drops on the start cycle.
  - Addresses restart at 0; the second polynomial is packed correctly.

Source files
------------

// File: rtl/poly_store_control_bram_pkg.sv
// Shared constants and FSM encoding for the polynomial store controller and
// its coefficient packer.
package poly_store_control_bram_pkg;

  localparam int POLY_N       = 256;
  localparam int SABER_COEF_W = 13;
  localparam int BRAM_WORD_W  = 64;
  localparam int POLY_WORDS   = 52;
  localparam int BRAM_ADDR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DONE = 2'd2
  } store_state_e;

endpackage

// File: rtl/poly_store_control_bram_if.sv
// Coefficient stream in, BRAM write port and status out, bundled for the
// store controller. The controller takes the slave side.
interface poly_store_control_bram_if
  import poly_store_control_bram_pkg::*;
#(
  parameter int COEF_W = SABER_COEF_W,
  parameter int WORD_W = BRAM_WORD_W,
  parameter int ADDR_W = BRAM_ADDR_W
) ();

  logic              start;
  logic [COEF_W-1:0] coef_in;
  logic              coef_valid;
  logic              coef_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata;
  logic              busy;
  logic              done;

  modport master (
    output start, coef_in, coef_valid,
    input  coef_ready, we, waddr, wdata, busy, done
  );

  modport slave (
    input  start, coef_in, coef_valid,
    output coef_ready, we, waddr, wdata, busy, done
  );

endinterface

// File: rtl/poly_coef_packer.sv
// Packs narrow coefficients LSB-first into wide words; raises emit on the
// accept that completes a word, with the finished word on word_o.
module poly_coef_packer #(
  parameter int COEF_W = 13,
  parameter int WORD_W = 64,
  parameter int BUF_W  = WORD_W + COEF_W - 1,
  parameter int FILL_W = $clog2(WORD_W + COEF_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [COEF_W-1:0] coef_i,
  output logic [WORD_W-1:0] word_o,
  output logic              emit_o
);

  logic [BUF_W-1:0]  buf_q, buf_d, merged;
  logic [FILL_W-1:0] fill_q, fill_d, fill_sum;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    merged   = buf_q | (BUF_W'(coef_i) << fill_q);
    fill_sum = fill_q + FILL_W'(COEF_W);
    emit_o   = accept_i && (fill_sum >= FILL_W'(WORD_W));
    word_o   = merged[WORD_W-1:0];
    buf_d    = buf_q;
    fill_d   = fill_q;
    if (clear_i) begin
      buf_d  = '0;
      fill_d = '0;
    end else if (accept_i) begin
      if (emit_o) begin
        // Carry the coefficient bits that spilled past the finished word.
        buf_d  = merged >> WORD_W;
        fill_d = fill_sum - FILL_W'(WORD_W);
      end else begin
        buf_d  = merged;
        fill_d = fill_sum;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/poly_store_control_bram.sv
// Write-side polynomial controller: packs 256 x 13-bit coefficients into
// 52 x 64-bit BRAM words written at addresses 0..51, then signals done.
module poly_store_control_bram
  import poly_store_control_bram_pkg::*;
#(
  parameter int COEF_W  = SABER_COEF_W,
  parameter int N_COEF  = POLY_N,
  parameter int WORD_W  = BRAM_WORD_W,
  parameter int N_WORDS = POLY_WORDS,
  parameter int ADDR_W  = BRAM_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  poly_store_control_bram_if.slave  bus
);

  // N_COEF*COEF_W must equal N_WORDS*WORD_W so the last coefficient closes
  // the last word exactly and nothing is left in the packer.
  localparam int CNT_W = $clog2(N_COEF + 1);

  store_state_e      state_q, state_d;
  logic [CNT_W-1:0]  coef_count_q, coef_count_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;

  logic              coef_ready;
  logic              accept;
  logic              clear;
  logic              emit;
  logic [WORD_W-1:0] packed_word;

  assign coef_ready = (state_q == ST_PACK) && (coef_count_q < CNT_W'(N_COEF));
  assign accept     = bus.coef_valid && coef_ready;

  poly_coef_packer #(
    .COEF_W (COEF_W),
    .WORD_W (WORD_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (clear),
    .accept_i (accept),
    .coef_i   (bus.coef_in),
    .word_o   (packed_word),
    .emit_o   (emit)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_PACK;
          clear   = 1'b1;
        end
      end
      ST_PACK: begin
        // Enter DONE on the same edge that launches the final word write.
        if (emit && (word_count_q == ADDR_W'(N_WORDS - 1))) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    coef_count_d = coef_count_q;
    word_count_d = word_count_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    if (clear) begin
      coef_count_d = '0;
      word_count_d = '0;
    end else if (accept) begin
      coef_count_d = coef_count_q + 1'b1;
      if (emit) begin
        we_d         = 1'b1;
        waddr_d      = word_count_q;
        wdata_d      = packed_word;
        word_count_d = word_count_q + 1'b1;
      end
    end
  end

  // NOTE: every register here, including the wide write-data holding register,
  // is reset so the BRAM port shows zeros after reset rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      coef_count_q <= '0;
      word_count_q <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      coef_count_q <= coef_count_d;
      word_count_q <= word_count_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.coef_ready = coef_ready;
  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.busy       = (state_q == ST_PACK);
  assign bus.done       = (state_q == ST_DONE);

endmodule
